// File: rtl/reg_writeback_pkg.sv
// Shared definitions for the register-bank write path.
package reg_writeback_pkg;

    // Widths common with the register bank.
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    // One completed result; addr sits in the MSBs so the queue can expose it as a key.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] ext;
    } wbEntry_t;

endpackage

// File: rtl/reg_writeback_if.sv
// Result handshake from execute/memory stages into the write-back queue.
interface reg_writeback_if;
    import reg_writeback_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] in_ext;

    modport master (
        output in_valid,
        output in_addr,
        output in_data,
        output in_ext,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_addr,
        input  in_data,
        input  in_ext,
        output in_ready
    );

endinterface

// File: rtl/reg_writeback_wb_fifo.sv
// Generic circular queue with push/pop/flush, exposing per-entry keys and a valid mask.
module wb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned KEY_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       pushData,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       popData,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic [DEPTH*KEY_W-1:0] keys,
    output logic [DEPTH-1:0]       validMask
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] fullCount = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtrQ, rdPtrQ;
    logic [PTR_W:0]   countQ;
    logic             doPush, doPop;

    assign full    = (countQ == fullCount);
    assign empty   = (countQ == '0);
    assign doPush  = push && !full && !flush;
    assign doPop   = pop && !empty && !flush;
    assign popData = mem[rdPtrQ];
    assign count   = countQ;

    // Pointer and occupancy update; flush wins over push and pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            countQ <= '0;
        end else if (flush) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            countQ <= '0;
        end else begin
            if (doPush) wrPtrQ <= wrPtrQ + 1'b1;
            if (doPop)  rdPtrQ <= rdPtrQ + 1'b1;
            case ({doPush, doPop})
                2'b10:   countQ <= countQ + 1'b1;
                2'b01:   countQ <= countQ - 1'b1;
                default: countQ <= countQ;
            endcase
        end
    end

    // Storage needs no reset; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtrQ] <= pushData;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : gSlot
        logic [PTR_W-1:0] offset;
        // Distance from head, modulo DEPTH; slot is live if it lies within count.
        assign offset       = PTR_W'(i) - rdPtrQ;
        assign validMask[i] = ({1'b0, offset} < countQ);
        assign keys[i*KEY_W +: KEY_W] = mem[i][WIDTH-1 -: KEY_W];
    end

endmodule

// File: rtl/reg_writeback.sv
// Write-side initiator: queues results, drains one per cycle to the register bank,
// and flags read-after-write hazards against queued or in-flight writes.
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    reg_writeback_if.slave         inBus,
    input  logic                   hold,
    input  logic                   flush,
    output logic                   RegWrite,
    output logic [ADDR_W-1:0]      wrAddr,
    output logic [DATA_W-1:0]      wrData,
    output logic [DATA_W-1:0]      wrDataExt,
    input  logic [ADDR_W-1:0]      rdAddrA,
    input  logic [ADDR_W-1:0]      rdAddrB,
    output logic                   hazardA,
    output logic                   hazardB,
    output logic [$clog2(DEPTH):0] count
);

    wbEntry_t                pushEntry, headEntry;
    logic                    full, empty, push, pop;
    logic [DEPTH*ADDR_W-1:0] keys;
    logic [DEPTH-1:0]        validMask;

    logic              regWriteQ;
    logic [ADDR_W-1:0] wrAddrQ;
    logic [DATA_W-1:0] wrDataQ, wrDataExtQ;
    logic              hitA, hitB;

    assign inBus.in_ready = !full;
    // Writes to r0 complete the handshake but never occupy a slot.
    assign push      = inBus.in_valid && !full && (inBus.in_addr != '0) && !flush;
    assign pop       = !empty && !hold && !flush;
    assign pushEntry = {inBus.in_addr, inBus.in_data, inBus.in_ext};

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(wbEntry_t)),
        .KEY_W (ADDR_W)
    ) uFifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pushData  (pushEntry),
        .pop       (pop),
        .flush     (flush),
        .popData   (headEntry),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .keys      (keys),
        .validMask (validMask)
    );

    // Output stage: head is registered onto the write port; data holds when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regWriteQ  <= 1'b0;
            wrAddrQ    <= '0;
            wrDataQ    <= '0;
            wrDataExtQ <= '0;
        end else if (pop) begin
            regWriteQ  <= 1'b1;
            wrAddrQ    <= headEntry.addr;
            wrDataQ    <= headEntry.data;
            wrDataExtQ <= headEntry.ext;
        end else begin
            regWriteQ  <= 1'b0;
        end
    end

    assign RegWrite  = regWriteQ;
    assign wrAddr    = wrAddrQ;
    assign wrData    = wrDataQ;
    assign wrDataExt = wrDataExtQ;

    // Compare both read addresses against every live entry and the in-flight write.
    always_comb begin
        hitA = 1'b0;
        hitB = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (validMask[i] && (keys[i*ADDR_W +: ADDR_W] == rdAddrA)) hitA = 1'b1;
            if (validMask[i] && (keys[i*ADDR_W +: ADDR_W] == rdAddrB)) hitB = 1'b1;
        end
        if (regWriteQ && (wrAddrQ == rdAddrA)) hitA = 1'b1;
        if (regWriteQ && (wrAddrQ == rdAddrB)) hitB = 1'b1;
    end

    // r0 is hard-wired, so reads of it never conflict.
    assign hazardA = hitA && (rdAddrA != '0);
    assign hazardB = hitB && (rdAddrB != '0);

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback using a cycle-level scoreboard model.
module tb_reg_writeback;
    import reg_writeback_pkg::*;

    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              hold, flush;
    logic              RegWrite;
    logic [ADDR_W-1:0] wrAddr;
    logic [DATA_W-1:0] wrData, wrDataExt;
    logic [ADDR_W-1:0] rdAddrA, rdAddrB;
    logic              hazardA, hazardB;
    logic [2:0]        count;

    reg_writeback_if inBus ();

    reg_writeback #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .inBus     (inBus.slave),
        .hold      (hold),
        .flush     (flush),
        .RegWrite  (RegWrite),
        .wrAddr    (wrAddr),
        .wrData    (wrData),
        .wrDataExt (wrDataExt),
        .rdAddrA   (rdAddrA),
        .rdAddrB   (rdAddrB),
        .hazardA   (hazardA),
        .hazardB   (hazardB),
        .count     (count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Scoreboard: entries accepted but not yet drained, plus the modelled output registers.
    wbEntry_t          sbq[$];
    logic              mWr;
    logic [ADDR_W-1:0] mAddr;
    logic [DATA_W-1:0] mData, mExt;

    task automatic tick();
        int       sz;
        wbEntry_t e;
        @(posedge clk);
        sz = sbq.size();
        if (flush) begin
            sbq.delete();
            mWr = 1'b0;
        end else begin
            if (sz > 0 && !hold) begin
                e     = sbq.pop_front();
                mWr   = 1'b1;
                mAddr = e.addr;
                mData = e.data;
                mExt  = e.ext;
            end else begin
                mWr = 1'b0;
            end
            if (inBus.in_valid && sz < DEPTH && inBus.in_addr != '0)
                sbq.push_back({inBus.in_addr, inBus.in_data, inBus.in_ext});
        end
        #1;
    endtask

    function automatic logic expHaz(input logic [ADDR_W-1:0] a);
        if (a == '0) return 1'b0;
        foreach (sbq[i]) if (sbq[i].addr == a) return 1'b1;
        return mWr && (mAddr == a);
    endfunction

    task automatic offer(input int a, input int d, input int x);
        inBus.in_valid = 1'b1;
        inBus.in_addr  = ADDR_W'(a);
        inBus.in_data  = DATA_W'(d);
        inBus.in_ext   = DATA_W'(x);
    endtask

    task automatic idle();
        inBus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; hold = 1'b0; flush = 1'b0;
        inBus.in_valid = 1'b0; inBus.in_addr = '0; inBus.in_data = '0; inBus.in_ext = '0;
        rdAddrA = 5'd3; rdAddrB = 5'd4;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %0b want 0", RegWrite); end
        checks++; if (wrAddr !== '0) begin errors++; $display("FAIL reset_wraddr got %0d want 0", wrAddr); end
        checks++; if (wrData !== '0 || wrDataExt !== '0) begin errors++; $display("FAIL reset_wrdata got %h/%h want 0/0", wrData, wrDataExt); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (inBus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", inBus.in_ready); end
        checks++; if (hazardA !== 1'b0 || hazardB !== 1'b0) begin errors++; $display("FAIL reset_hazard got %0b%0b want 00", hazardA, hazardB); end
        mWr = 1'b0; mAddr = '0; mData = '0; mExt = '0;
        reset = 1'b1;
    endtask

    task automatic test_single();
        offer(10, 'h15, 'h4D);
        tick();
        idle();
        checks++; if (count !== 3'd1 || RegWrite !== 1'b0) begin errors++; $display("FAIL single_accept got count=%0d rw=%0b want 1/0", count, RegWrite); end
        tick();
        checks++; if (RegWrite !== 1'b1 || wrAddr !== 5'd10) begin errors++; $display("FAIL single_write got rw=%0b addr=%0d want 1/10", RegWrite, wrAddr); end
        checks++; if (wrData !== 32'h15 || wrDataExt !== 32'h4D) begin errors++; $display("FAIL single_data got %h/%h want 15/4d", wrData, wrDataExt); end
        tick();
        checks++; if (RegWrite !== 1'b0 || wrAddr !== 5'd10) begin errors++; $display("FAIL single_after got rw=%0b addr=%0d want 0/10", RegWrite, wrAddr); end
    endtask

    task automatic test_fill();
        hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            offer(i, 'h100 + i, 'h200 + i);
            tick();
        end
        checks++; if (count !== 3'd4 || inBus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_full got count=%0d ready=%0b want 4/0", count, inBus.in_ready); end
        offer(5, 'h105, 'h205);
        tick();
        checks++; if (count !== 3'(sbq.size()) || count !== 3'd4) begin errors++; $display("FAIL fill_reject got count=%0d want 4", count); end
        idle();
        hold = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++; if (RegWrite !== 1'b1 || wrAddr !== ADDR_W'(k)) begin errors++; $display("FAIL fill_order%0d got rw=%0b addr=%0d want 1/%0d", k, RegWrite, wrAddr, k); end
            checks++; if (wrData !== mData || wrDataExt !== mExt) begin errors++; $display("FAIL fill_data%0d got %h/%h want %h/%h", k, wrData, wrDataExt, mData, mExt); end
            checks++; if (inBus.in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d got %0b want 1", k, inBus.in_ready); end
        end
        tick();
        checks++; if (RegWrite !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL fill_done got rw=%0b count=%0d want 0/0", RegWrite, count); end
    endtask

    task automatic test_hazard();
        hold = 1'b1;
        offer(15, 'h03, 0);
        tick();
        idle();
        rdAddrA = 5'd15; rdAddrB = 5'd10;
        #1;
        checks++; if (hazardA !== 1'b1 || hazardB !== 1'b0) begin errors++; $display("FAIL hazard_queued got %0b%0b want 10", hazardA, hazardB); end
        rdAddrA = 5'd0;
        #1;
        checks++; if (hazardA !== 1'b0) begin errors++; $display("FAIL hazard_r0 got %0b want 0", hazardA); end
        rdAddrA = 5'd15;
        hold = 1'b0;
        tick();
        checks++; if (RegWrite !== 1'b1 || hazardA !== expHaz(rdAddrA)) begin errors++; $display("FAIL hazard_inflight got rw=%0b hz=%0b want 1/1", RegWrite, hazardA); end
        tick();
        checks++; if (hazardA !== 1'b0 || hazardB !== 1'b0) begin errors++; $display("FAIL hazard_drained got %0b%0b want 00", hazardA, hazardB); end
    endtask

    task automatic test_addr0_pushpop();
        offer(0, 'hDEAD, 'hBEEF);
        tick();
        idle();
        checks++; if (count !== 3'd0 || inBus.in_ready !== 1'b1) begin errors++; $display("FAIL addr0_count got %0d want 0", count); end
        tick();
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL addr0_nowrite got %0b want 0", RegWrite); end
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(7 + i, 'h70 + i, 'h80 + i);
            tick();
        end
        hold = 1'b0;
        offer(11, 'hB0, 'hB1);
        tick();
        idle();
        checks++; if (count !== 3'd3 || RegWrite !== 1'b1 || wrAddr !== 5'd7) begin errors++; $display("FAIL pushpop got count=%0d rw=%0b addr=%0d want 3/1/7", count, RegWrite, wrAddr); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (RegWrite !== mWr || wrAddr !== mAddr || wrData !== mData) begin errors++; $display("FAIL pushpop_drain%0d got rw=%0b addr=%0d data=%h want %0b/%0d/%h", k, RegWrite, wrAddr, wrData, mWr, mAddr, mData); end
        end
        tick();
    endtask

    task automatic test_flush();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(20 + i, 'h20 + i, 0);
            tick();
        end
        hold = 1'b0;
        flush = 1'b1;
        offer(23, 'h23, 0);
        #1;
        checks++; if (inBus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %0b want 1", inBus.in_ready); end
        tick();
        flush = 1'b0;
        idle();
        rdAddrA = 5'd21;
        #1;
        checks++; if (count !== 3'd0 || RegWrite !== 1'b0) begin errors++; $display("FAIL flush_clear got count=%0d rw=%0b want 0/0", count, RegWrite); end
        checks++; if (hazardA !== 1'b0) begin errors++; $display("FAIL flush_hazard got %0b want 0", hazardA); end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL flush_nowrite%0d got %0b want 0", k, RegWrite); end
        end
    endtask

    task automatic test_async_reset();
        hold = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            offer(i, 'hA0 + i, 'hC0 + i);
            tick();
        end
        idle();
        hold = 1'b0;
        tick();
        checks++; if (RegWrite !== 1'b1 || wrAddr !== 5'd1) begin errors++; $display("FAIL areset_predrain got rw=%0b addr=%0d want 1/1", RegWrite, wrAddr); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (RegWrite !== 1'b0 || wrAddr !== '0) begin errors++; $display("FAIL areset_out got rw=%0b addr=%0d want 0/0", RegWrite, wrAddr); end
        checks++; if (wrData !== '0 || wrDataExt !== '0) begin errors++; $display("FAIL areset_data got %h/%h want 0/0", wrData, wrDataExt); end
        checks++; if (count !== 3'd0 || inBus.in_ready !== 1'b1) begin errors++; $display("FAIL areset_count got count=%0d ready=%0b want 0/1", count, inBus.in_ready); end
        sbq.delete();
        mWr = 1'b0; mAddr = '0; mData = '0; mExt = '0;
        @(negedge clk);
        reset = 1'b1;
        tick();
        checks++; if (RegWrite !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL areset_after got rw=%0b count=%0d want 0/0", RegWrite, count); end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_single();
        test_fill();
        test_hazard();
        test_addr0_pushpop();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
